rs232_rx: RTL and testbench

- UART receiver for 8N1 serial frames: idle-high line, one start bit (0), 8 data bits LSB first, one stop bit (1).
- Samples the line with a 16x oversampling tick generated internally from clk.
- Delivers each received byte with a one-cycle valid strobe, and flags frames with a bad stop bit.
- Serves as the receive half of the RS-232 link, paired with the existing transmitter at the same baud rate.

---
 rtl/rs232_rx.sv | 247 ++++++++++++++++++++++++
 tb/tb_rs232_rx.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/rs232_rx.sv
// 16x-oversampled UART receiver, 8N1 by default.
// Define RS232_RX_PARITY_EN for 8E1 framing with an even-parity check.
module rs232_rx #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DIV        = CLK_FREQ / (BAUD * OVERSAMPLE)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_data,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int              TW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0]   TICK_LAST = TW'(DIV - 1);
  localparam logic [3:0]      SAMP_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]      SAMP_MID  = 4'(OVERSAMPLE / 2 - 1);

`ifdef RS232_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_PARITY  = 3'd3,
    ST_STOP    = 3'd4,
    ST_WAIT_HI = 3'd5
  } state_t;

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction
`else
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd4,
    ST_WAIT_HI = 3'd5
  } state_t;
`endif

  state_t          state_r, state_nxt_s;
  logic            sync1_r, rxs_r, prev_r;
  logic            fall_s;
  logic [TW-1:0]   tick_cnt_r;
  logic            tick_s, tick_clr_s;
  logic [3:0]      samp_cnt_r, samp_nxt_s;
  logic            samp_mid_s, samp_end_s;
  logic [2:0]      bit_idx_r, bit_nxt_s;
  logic [7:0]      shift_r, shift_nxt_s;
  logic [7:0]      data_r, data_nxt_s;
  logic            valid_r, valid_nxt_s;
  logic            ferr_r, ferr_nxt_s;
  logic            busy_r, busy_nxt_s;
`ifdef RS232_RX_PARITY_EN
  logic            par_err_r, par_err_nxt_s;
`endif

  // rx_data is asynchronous: two flops for metastability, a third for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 1'b1;
      rxs_r   <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= rx_data;
      rxs_r   <= sync1_r;
      prev_r  <= rxs_r;
    end
  end

  assign fall_s = prev_r & ~rxs_r;

  // Oversampling tick divider; realigned to the accepted start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_r <= '0;
    end else if (tick_clr_s) begin
      tick_cnt_r <= '0;
    end else if (tick_s) begin
      tick_cnt_r <= '0;
    end else begin
      tick_cnt_r <= tick_cnt_r + TW'(1);
    end
  end

  assign tick_s     = (tick_cnt_r == TICK_LAST);
  assign samp_mid_s = tick_s && (samp_cnt_r == SAMP_MID);
  assign samp_end_s = tick_s && (samp_cnt_r == SAMP_LAST);

  // Next-state and datapath decisions; all strobes default low.
  always_comb begin
    state_nxt_s = state_r;
    samp_nxt_s  = samp_cnt_r;
    bit_nxt_s   = bit_idx_r;
    shift_nxt_s = shift_r;
    data_nxt_s  = data_r;
    valid_nxt_s = 1'b0;
    ferr_nxt_s  = 1'b0;
    tick_clr_s  = 1'b0;
`ifdef RS232_RX_PARITY_EN
    par_err_nxt_s = par_err_r;
`endif
    case (state_r)
      ST_IDLE: begin
        samp_nxt_s = 4'd0;
        bit_nxt_s  = 3'd0;
        if (fall_s) begin
          state_nxt_s = ST_START;
          tick_clr_s  = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (samp_mid_s) begin
          samp_nxt_s = 4'd0;
          bit_nxt_s  = 3'd0;
          // A line back high at mid start bit was only a glitch.
          if (rxs_r) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_DATA;
          end
        end else if (tick_s) begin
          samp_nxt_s = samp_cnt_r + 4'd1;
        end else begin
          samp_nxt_s = samp_cnt_r;
        end
      end
      ST_DATA: begin
        if (samp_end_s) begin
          samp_nxt_s  = 4'd0;
          shift_nxt_s = {rxs_r, shift_r[7:1]};
          if (bit_idx_r == 3'd7) begin
            bit_nxt_s = 3'd0;
`ifdef RS232_RX_PARITY_EN
            state_nxt_s = ST_PARITY;
`else
            state_nxt_s = ST_STOP;
`endif
          end else begin
            bit_nxt_s = bit_idx_r + 3'd1;
          end
        end else if (tick_s) begin
          samp_nxt_s = samp_cnt_r + 4'd1;
        end else begin
          samp_nxt_s = samp_cnt_r;
        end
      end
`ifdef RS232_RX_PARITY_EN
      ST_PARITY: begin
        if (samp_end_s) begin
          samp_nxt_s    = 4'd0;
          par_err_nxt_s = rxs_r ^ even_par(shift_r);
          state_nxt_s   = ST_STOP;
        end else if (tick_s) begin
          samp_nxt_s = samp_cnt_r + 4'd1;
        end else begin
          samp_nxt_s = samp_cnt_r;
        end
      end
`endif
      ST_STOP: begin
        if (samp_end_s) begin
          samp_nxt_s = 4'd0;
          data_nxt_s = shift_r;
          if (rxs_r) begin
            state_nxt_s = ST_IDLE;
`ifdef RS232_RX_PARITY_EN
            if (par_err_r) begin
              ferr_nxt_s = 1'b1;
            end else begin
              valid_nxt_s = 1'b1;
            end
`else
            valid_nxt_s = 1'b1;
`endif
          end else begin
            ferr_nxt_s  = 1'b1;
            state_nxt_s = ST_WAIT_HI;
          end
        end else if (tick_s) begin
          samp_nxt_s = samp_cnt_r + 4'd1;
        end else begin
          samp_nxt_s = samp_cnt_r;
        end
      end
      ST_WAIT_HI: begin
        // Hold off a break or stuck-low line until it returns to idle.
        if (rxs_r) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_HI;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    busy_nxt_s = (state_nxt_s != ST_IDLE);
  end

  // FSM state, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      samp_cnt_r <= 4'd0;
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'h00;
      data_r     <= 8'h00;
      valid_r    <= 1'b0;
      ferr_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      samp_cnt_r <= samp_nxt_s;
      bit_idx_r  <= bit_nxt_s;
      shift_r    <= shift_nxt_s;
      data_r     <= data_nxt_s;
      valid_r    <= valid_nxt_s;
      ferr_r     <= ferr_nxt_s;
      busy_r     <= busy_nxt_s;
    end
  end

`ifdef RS232_RX_PARITY_EN
  // Parity verdict held from mid parity bit until the stop bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_err_r <= 1'b0;
    end else begin
      par_err_r <= par_err_nxt_s;
    end
  end
`endif

  assign data      = data_r;
  assign valid     = valid_r;
  assign frame_err = ferr_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_rs232_rx.sv
// Scoreboard bench for rs232_rx: directed frames push expected strobes, a monitor checks them.
module tb_rs232_rx;

  localparam int BIT_CLKS = 432;
`ifdef RS232_RX_PARITY_EN
  localparam int LAT_NOM = 4538;
`else
  localparam int LAT_NOM = 4106;
`endif
  localparam int LAT_TOL = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_data = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  rs232_rx dut (
    .clk(clk), .rst(rst), .rx_data(rx_data),
    .data(data), .valid(valid), .frame_err(frame_err), .busy(busy)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
    logic       busy;
    int         start;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    int   lat;
    if (rst && (valid || frame_err)) begin
      if (valid && frame_err) begin
        checks++;
        errors++;
        $display("FAIL strobe_excl: valid=%0b frame_err=%0b expected not both", valid, frame_err);
      end else if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: valid=%0b frame_err=%0b data=%0h expected none", valid, frame_err, data);
      end else begin
        e = q.pop_front();
        chk("strobe_kind_frame_err", {31'd0, frame_err}, {31'd0, e.is_err});
        chk("data", {24'd0, data}, {24'd0, e.data});
        chk("busy_at_strobe", {31'd0, busy}, {31'd0, e.busy});
        lat = cyc - e.start;
        checks++;
        if (lat < LAT_NOM - LAT_TOL || lat > LAT_NOM + LAT_TOL) begin
          errors++;
          $display("FAIL latency: got %0d clks expected %0d +/- %0d", lat, LAT_NOM, LAT_TOL);
        end
      end
    end
  end

  task automatic drive_bit(input logic v);
    rx_data = v;
    repeat (BIT_CLKS) @(posedge clk);
  endtask

  // Called at a posedge; returns at a posedge with the stop level still on the line.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                            input logic push, input logic exp_err, input logic exp_busy);
    exp_t e;
    if (push) begin
      e.is_err = exp_err;
      e.data   = b;
      e.busy   = exp_busy;
      e.start  = cyc;
      q.push_back(e);
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef RS232_RX_PARITY_EN
    drive_bit(par);
`else
    if (par === 1'bx) rx_data = 1'b1;
`endif
    drive_bit(stop);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_data"}, {24'd0, data}, 32'd0);
    chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
    chk({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    rx_data = 1'b1;
    repeat (5) @(posedge clk);
    #1 check_idle_outputs("reset");
    @(posedge clk);
    rst = 1'b1;
    repeat (20) @(posedge clk);

    // 0x55, even parity 0
    send_frame(8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (BIT_CLKS) @(posedge clk);

    // 0xA3 (parity 0) then 0x00 (parity 0) with no idle gap
    send_frame(8'hA3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (BIT_CLKS) @(posedge clk);

    // Short low glitch must be rejected
    rx_data = 1'b0;
    repeat (100) @(posedge clk);
    rx_data = 1'b1;
    repeat (2 * BIT_CLKS) @(posedge clk);
    #1 chk("glitch_busy_idle", {31'd0, busy}, 32'd0);
    @(posedge clk);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (BIT_CLKS) @(posedge clk);

    // 0xFF (parity 0) with stop bit 0, line low 3 bit times in total
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (2 * BIT_CLKS) @(posedge clk);
    #1 chk("wait_hi_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    rx_data = 1'b1;
    repeat (10) @(posedge clk);
    #1 chk("wait_hi_release_busy", {31'd0, busy}, 32'd0);
    chk("data_after_ferr", {24'd0, data}, 32'h0000_00FF);
    @(posedge clk);
    repeat (BIT_CLKS) @(posedge clk);

    // Reset in the middle of 0x81's data bits
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    rst = 1'b0;
    rx_data = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_idle_outputs("midframe_reset");
    @(posedge clk);
    rst = 1'b1;
    repeat (BIT_CLKS) @(posedge clk);
    send_frame(8'h7E, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (BIT_CLKS) @(posedge clk);

`ifdef RS232_RX_PARITY_EN
    // 0x03 has two ones: parity 0 is good, parity 1 is an error
    send_frame(8'h03, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (BIT_CLKS) @(posedge clk);
    send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (BIT_CLKS) @(posedge clk);
`endif

    repeat (BIT_CLKS) @(posedge clk);
    #1 chk("scoreboard_drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
